// File: rtl/count_seq_if.sv
// Observed counter stream into the sequence checker, plus the checker's status back out.
interface count_seq_if #(
    parameter int ERRW = 8
);
    // Strobe-only handshake: valid marks count_in as a new sequence step this cycle.
    // There is no ready; the checker samples every valid cycle without backpressure.
    logic [2:0]      count_in;
    logic            valid;
    logic            mode;
    logic            locked;
    logic            error;
    logic [1:0]      position;
    logic [ERRW-1:0] err_count;

    modport master (
        output count_in, valid, mode,
        input  locked, error, position, err_count
    );

    modport slave (
        input  count_in, valid, mode,
        output locked, error, position, err_count
    );
endinterface

// File: rtl/count_sequence_checker.sv
// Locks onto the 4-entry count sequence for the selected mode and tallies mismatches.
// Optional macro STICKY_ERROR_EN: error holds high from the first locked mismatch until reset.
module count_sequence_checker #(
    parameter logic [11:0] SEQ0 = 12'o7421,
    parameter logic [11:0] SEQ1 = 12'o0356,
    parameter int          ERRW = 8
) (
    input  logic       clk,
    input  logic       reset,
    count_seq_if.slave bus,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t          state_q;
    logic            mode_q;
    logic            locked_q;
    logic            error_q;
    logic [1:0]      pos_q;
    logic [ERRW-1:0] err_q;

    logic            hit;
    logic [1:0]      hit_idx;
    logic [2:0]      expected;

    function automatic logic [2:0] entry(input logic m, input logic [1:0] i);
        logic [11:0] s;
        logic [2:0]  e;
        s = m ? SEQ1 : SEQ0;
        case (i)
            2'd0:    e = s[2:0];
            2'd1:    e = s[5:3];
            2'd2:    e = s[8:6];
            default: e = s[11:9];
        endcase
        return e;
    endfunction

    // Search is always against the incoming mode so a sample arriving with a mode flip
    // is hunted in the new sequence.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!hit && entry(bus.mode, i[1:0]) == bus.count_in) begin
                hit     = 1'b1;
                hit_idx = i[1:0];
            end
        end
        expected = entry(bus.mode, pos_q + 2'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HUNT;
            mode_q   <= 1'b0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            pos_q    <= 2'd0;
            err_q    <= '0;
        end else begin
            mode_q <= bus.mode;
`ifndef STICKY_ERROR_EN
            error_q <= 1'b0;
`endif
            if (bus.mode != mode_q) begin
                locked_q <= 1'b0;
                if (bus.valid && hit) begin
                    pos_q   <= hit_idx;
                    state_q <= SYNC;
                end else begin
                    state_q <= HUNT;
                end
            end else if (bus.valid) begin
                case (state_q)
                    SYNC: begin
                        if (bus.count_in == expected) begin
                            pos_q    <= pos_q + 2'd1;
                            locked_q <= 1'b1;
                            state_q  <= LOCKED;
                        end else if (hit) begin
                            pos_q   <= hit_idx;
                            state_q <= SYNC;
                        end else begin
                            state_q <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (bus.count_in == expected) begin
                            pos_q <= pos_q + 2'd1;
                        end else begin
                            error_q  <= 1'b1;
                            locked_q <= 1'b0;
                            state_q  <= ERR;
                            if (err_q != '1) begin
                                err_q <= err_q + ERRW'(1);
                            end
                        end
                    end
                    default: begin
                        // HUNT and ERR both search for an entry point on a valid sample.
                        if (hit) begin
                            pos_q   <= hit_idx;
                            state_q <= SYNC;
                        end else begin
                            state_q <= HUNT;
                        end
                    end
                endcase
            end else if (state_q == ERR) begin
                state_q <= HUNT;
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.error     = error_q;
    assign bus.position  = pos_q;
    assign bus.err_count = err_q;
    assign state         = state_q;
endmodule

// File: tb/tb_count_sequence_checker.sv
// Bench for count_sequence_checker: vector table, hand sequences and random stream vs. a model.
module tb_count_sequence_checker;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state;

    count_seq_if #(.ERRW(8)) bus ();

    count_sequence_checker #(.ERRW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .state (state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [11:0] exp_q[$];

    int seqs[2][4] = '{'{1, 2, 4, 7}, '{6, 5, 3, 0}};

    // Model: m_run 0 = searching, 1 = one anchored sample, 2 = locked.
    bit m_mode_q;
    int m_run, m_pos, m_cnt;
    bit m_err;

    typedef struct {
        bit       v;
        bit [2:0] c;
        bit       m;
        bit       l;
        bit       e;
        bit [1:0] p;
        bit [7:0] n;
        bit [1:0] s;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic model_reset();
        m_mode_q = 1'b0;
        m_run    = 0;
        m_pos    = 0;
        m_cnt    = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_hunt(input bit [2:0] c, input bit m);
        m_run = 0;
        for (int i = 0; i < 4; i++) begin
            if (seqs[m][i] == int'(c)) begin
                m_pos = i;
                m_run = 1;
            end
        end
    endtask

    task automatic model_step(input bit v, input bit [2:0] c, input bit m);
        bit pulse;
        int nxt;
        pulse = 1'b0;
        if (m != m_mode_q) begin
            m_run = 0;
            if (v) model_hunt(c, m);
        end else if (v) begin
            nxt = (m_pos + 1) % 4;
            if (m_run >= 1 && int'(c) == seqs[m][nxt]) begin
                m_pos = nxt;
                m_run = 2;
            end else if (m_run >= 2) begin
                pulse = 1'b1;
                if (m_cnt < 255) m_cnt++;
                m_run = 0;
            end else begin
                model_hunt(c, m);
            end
        end
        m_mode_q = m;
`ifdef STICKY_ERROR_EN
        m_err = m_err | pulse;
`else
        m_err = pulse;
`endif
    endtask

    function automatic logic [11:0] model_out();
        return {m_run >= 2, m_err, 2'(m_pos), 8'(m_cnt)};
    endfunction

    function automatic logic [11:0] dut_out();
        return {bus.locked, bus.error, bus.position, bus.err_count};
    endfunction

    task automatic drive(input bit v, input bit [2:0] c, input bit m, input bit r);
        @(negedge clk);
        reset        = r;
        bus.valid    = v;
        bus.count_in = c;
        bus.mode     = m;
    endtask

    task automatic step(input string name, input bit v, input bit [2:0] c, input bit m);
        drive(v, c, m, 1'b0);
        @(posedge clk);
        model_step(v, c, m);
        exp_q.push_back(model_out());
        #1;
        check(name, dut_out(), exp_q.pop_front());
    endtask

    task automatic do_reset(input string name, input bit v, input bit [2:0] c);
        drive(v, c, 1'b0, 1'b1);
        @(posedge clk);
        model_reset();
        #1;
        check({name, "_out"}, dut_out(), 12'h000);
        check({name, "_state"}, state, 2'd0);
    endtask

    function automatic vec_t mk(bit v, bit [2:0] c, bit m, bit l, bit e, bit [1:0] p, bit [7:0] n, bit [1:0] s);
        vec_t t;
        t.v = v; t.c = c; t.m = m; t.l = l; t.e = e; t.p = p; t.n = n; t.s = s;
        return t;
    endfunction

    initial begin
        bit seen_err;
        bit cur_m;
        bit rv;
        bit [2:0] rc;

        bus.valid    = 1'b0;
        bus.count_in = 3'd0;
        bus.mode     = 1'b0;
        model_reset();

        // state codes: 0 HUNT, 1 SYNC, 2 LOCKED, 3 ERR
        tbl.push_back(mk(1, 3'd1, 0, 0, 0, 2'd0, 8'd0, 2'd1));
        tbl.push_back(mk(1, 3'd2, 0, 1, 0, 2'd1, 8'd0, 2'd2));
        tbl.push_back(mk(1, 3'd4, 0, 1, 0, 2'd2, 8'd0, 2'd2));
        tbl.push_back(mk(1, 3'd7, 0, 1, 0, 2'd3, 8'd0, 2'd2));
        tbl.push_back(mk(1, 3'd1, 0, 1, 0, 2'd0, 8'd0, 2'd2));
        tbl.push_back(mk(1, 3'd2, 0, 1, 0, 2'd1, 8'd0, 2'd2));
        tbl.push_back(mk(1, 3'd4, 0, 1, 0, 2'd2, 8'd0, 2'd2));
        tbl.push_back(mk(1, 3'd2, 0, 0, 1, 2'd2, 8'd1, 2'd3));
        tbl.push_back(mk(1, 3'd4, 0, 0, 0, 2'd2, 8'd1, 2'd1));
        tbl.push_back(mk(1, 3'd7, 0, 1, 0, 2'd3, 8'd1, 2'd2));
        tbl.push_back(mk(0, 3'd7, 0, 1, 0, 2'd3, 8'd1, 2'd2));
        tbl.push_back(mk(1, 3'd1, 0, 1, 0, 2'd0, 8'd1, 2'd2));
        tbl.push_back(mk(1, 3'd6, 1, 0, 0, 2'd0, 8'd1, 2'd1));
        tbl.push_back(mk(1, 3'd5, 1, 1, 0, 2'd1, 8'd1, 2'd2));
        tbl.push_back(mk(1, 3'd3, 1, 1, 0, 2'd2, 8'd1, 2'd2));
        tbl.push_back(mk(1, 3'd3, 1, 0, 1, 2'd2, 8'd2, 2'd3));
        tbl.push_back(mk(0, 3'd3, 1, 0, 0, 2'd2, 8'd2, 2'd0));

        do_reset("reset0", 1'b0, 3'd0);

        seen_err = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            bit te;
            drive(tbl[i].v, tbl[i].c, tbl[i].m, 1'b0);
            @(posedge clk);
            model_step(tbl[i].v, tbl[i].c, tbl[i].m);
            #1;
`ifdef STICKY_ERROR_EN
            seen_err = seen_err | tbl[i].e;
            te = seen_err;
`else
            te = tbl[i].e;
`endif
            check($sformatf("vec%0d_out", i), dut_out(), {tbl[i].l, te, tbl[i].p, tbl[i].n});
            check($sformatf("vec%0d_state", i), state, tbl[i].s);
        end

        // Bursty strobe: held count during low phases must not disturb the lock.
        do_reset("reset1", 1'b0, 3'd0);
        step("burst_lead", 1'b1, 3'd1, 1'b0);
        step("burst_lead", 1'b1, 3'd2, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 30; k++)
                step("burst_hi", 1'b1, 3'(seqs[0][(m_pos + 1) % 4]), 1'b0);
            for (int k = 0; k < 80; k++)
                step("burst_lo", 1'b0, bus.count_in, 1'b0);
        end
        check("burst_locked", bus.locked, 1);
        check("burst_errcnt", bus.err_count, 0);

        // Saturation: 300 locked mismatches with a relock between each.
        do_reset("reset2", 1'b0, 3'd0);
        step("sat_lead", 1'b1, 3'd1, 1'b0);
        step("sat_lead", 1'b1, 3'd2, 1'b0);
        for (int k = 0; k < 300; k++) begin
            step("sat_miss", 1'b1, 3'd1, 1'b0);
            step("sat_resync", 1'b1, 3'd1, 1'b0);
            step("sat_relock", 1'b1, 3'd2, 1'b0);
        end
        check("sat_errcnt", bus.err_count, 255);
        step("sat_hold", 1'b1, 3'd1, 1'b0);
        check("sat_errcnt_hold", bus.err_count, 255);

        // Reset mid-operation, coinciding with a mismatch that would pulse error.
        do_reset("reset3", 1'b0, 3'd0);
        step("mid_lead", 1'b1, 3'd1, 1'b0);
        step("mid_lead", 1'b1, 3'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step("mid_miss", 1'b1, 3'd1, 1'b0);
            step("mid_resync", 1'b1, 3'd1, 1'b0);
            step("mid_relock", 1'b1, 3'd2, 1'b0);
        end
        step("mid_adv", 1'b1, 3'd4, 1'b0);
        check("mid_errcnt3", bus.err_count, 3);
        check("mid_locked", bus.locked, 1);
        do_reset("mid_reset", 1'b1, 3'd2);

`ifdef STICKY_ERROR_EN
        step("sticky_lead", 1'b1, 3'd1, 1'b0);
        step("sticky_lead", 1'b1, 3'd2, 1'b0);
        step("sticky_miss", 1'b1, 3'd1, 1'b0);
        step("sticky_resync", 1'b1, 3'd1, 1'b0);
        step("sticky_relock", 1'b1, 3'd2, 1'b0);
        step("sticky_adv", 1'b1, 3'd4, 1'b0);
        check("sticky_error_held", bus.error, 1);
        do_reset("sticky_reset", 1'b0, 3'd0);
`endif

        // Random stream, mostly following the sequence, with occasional mode flips.
        do_reset("reset4", 1'b0, 3'd0);
        cur_m = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 29) == 0) cur_m = ~cur_m;
            rv = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6) rc = 3'(seqs[cur_m][(m_pos + 1) % 4]);
            else rc = 3'($urandom_range(0, 7));
            step("rand", rv, rc, cur_m);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/count_sequence_checker.md
Name: count_sequence_checker

Overview:
- Receive-side monitor for the 3-bit mode-selectable counter output.
- Samples the count stream on each valid strobe, which is the counter's enable, and locks onto the expected 4-entry sequence for the current mode.
- Once locked, flags every deviation and keeps a saturating error tally.
- Sits beside the counter in the FSM lab designs as a self-checking consumer and as a bench scoreboard.

Parameters:
- SEQ0, 12'o7421, mode-0 sequence; entry i sits in bits [3i+2:3i] → 1,2,4,7 then wrap.
- SEQ1, 12'o0356, mode-1 sequence → 6,5,3,0 then wrap.
- ERRW, 8, width of err_count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- count_in  input  3  observed counter value
- valid  input  1  count_in is a new sequence step this cycle
- mode  input  1  selects SEQ0 (0) or SEQ1 (1)
- locked  output  1  tracking sequence correctly
- error  output  1  one-cycle pulse on mismatch while locked
- position  output  2  index of the last accepted value within the active sequence
- err_count  output  ERRW  saturating mismatch count

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: locked=0, error=0, position=0, err_count=0, state=HUNT, mode_q=0.
- All outputs are registered and reflect the sample taken on the previous clk edge (latency 1).
- Entries within each SEQ are distinct.
- expected = entry[(position+1) mod 4] of the sequence selected by mode. Position wraps 3→0.
- When valid=0: no state change; error is driven 0.
- States:
  - HUNT
    - valid and count_in matches an entry of the active SEQ: position=that index, go to SYNC.
    - No match: stay in HUNT, no error.
  - SYNC
    - valid and count_in==expected: position++, go to LOCKED, locked=1.
    - Mismatch: re-search as in HUNT, which may yield SYNC with a new position or HUNT. No error, no count.
  - LOCKED
    - valid and count_in==expected: position++.
    - Mismatch: error=1 for one cycle, err_count+1 saturating at all-ones, locked=0, go to ERR.
  - ERR
    - Single-cycle transit state; go to HUNT next cycle.
    - A valid sample arriving while in ERR is re-searched as in HUNT, so it may go directly to SYNC.
- Mode change: mode is registered into mode_q each cycle. mode≠mode_q drops locked and forces HUNT in that cycle, with no error and no count. A valid sample in the same cycle is hunted against the new mode's SEQ.
- Reset mid-operation: overrides everything including a pending error pulse. err_count clears.
- Repeated equal values (counter held) arrive with valid=0 and are ignored. A repeat with valid=1 is a mismatch.

Optional Feature:
- Macro STICKY_ERROR_EN.
- Defined:
  - error stays high from the first locked mismatch until reset.
  - The tally and FSM behave as without the macro; only the error output changes.
- Undefined:
  - error is a one-cycle pulse per mismatch as specified above.

Test Plan:
- Reset, then mode=0, valid each cycle with 1,2,4,7,1 → SYNC after 1; locked=1 the cycle after the 2 sample; position 1,2,3,0; error never 1.
- Locked on mode 0 after ...4, then valid with 2 instead of 7 → error=1 for exactly one cycle; err_count=1; locked=0; relocks after the sequence 4,7.
- valid toggling 30 cycles high / 80 cycles low with count_in held during low phases → locked stays 1, err_count stays 0.
- Locked in mode 0, flip mode to 1, feed 6,5,3 → no error; locked=0 after the flip; locked=1 after the 5 sample; position=2 after 3.
- Force 300 locked mismatches, relocking between each → err_count saturates at 255.
- Assert reset for 1 cycle mid-sequence while locked with err_count=3 → next cycle all outputs are 0 and state=HUNT.
- With STICKY_ERROR_EN defined, one mismatch → error stays 1 across relock until reset.
